// File: rtl/uart_stream_bridge.sv
// uart_stream_bridge
// Receives 8N1 UART bytes on rx, buffers them in a circular byte FIFO and
// hands them to the neighbouring board as LANES-byte words over a four-phase
// tsent/trecieve handshake. A running CRC-8 (poly 0x07, init 0x00, MSB first)
// over every accepted byte is exported for the display.
//
// Build option: define UART_PARITY_EN for 8E1 framing (even parity bit after
// bit 7; a mismatch rejects the byte). Undefined: plain 8N1.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   DEPTH_LOG2    FIFO depth = 2**DEPTH_LOG2 bytes (depth must be >= LANES)
//   LANES         bytes per output word (1, 2 or 4)
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   rx          UART serial input, idle high
//   flush       pulse: emit buffered bytes as a zero-padded partial word
//   crc_clear   pulse: CRC <- 0x00
//   data        output word, first byte in the top lane; stable while tsent
//   tsent       output word valid (request)
//   trecieve    acknowledge from receiver (asynchronous)
//   crc         CRC-8 of accepted bytes
//   fifo_count  bytes currently buffered
//   overflow    sticky: a byte was dropped because the FIFO was full
//   err_count   saturating count of rejected frames
module uart_stream_bridge #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned LANES        = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 flush,
  input  logic                 crc_clear,
  output logic [8*LANES-1:0]   data,
  output logic                 tsent,
  input  logic                 trecieve,
  output logic [7:0]           crc,
  output logic [DEPTH_LOG2:0]  fifo_count,
  output logic                 overflow,
  output logic [7:0]           err_count
);

  localparam int unsigned DATA_W   = 8 * LANES;
  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W    = DEPTH_LOG2 + 1;
  localparam int unsigned BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rxState_t;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
`endif

  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_SEND, TX_WAIT_ACK, TX_WAIT_REL} txState_t;

  // CRC-8, poly 0x07, one byte folded in MSB first
  function automatic logic [7:0] crc8Byte(input logic [7:0] cur, input logic [7:0] din);
    logic [7:0] r;
    r = cur ^ din;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers; rx resets to idle-high so reset release is not a start
  // ---------------------------------------------------------------------------
  logic rxMeta, rxSync, rxPrev;
  logic ackMeta, ackSync;
  logic rxFall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxMeta  <= 1'b1;
      rxSync  <= 1'b1;
      rxPrev  <= 1'b1;
      ackMeta <= 1'b0;
      ackSync <= 1'b0;
    end else begin
      rxMeta  <= rx;
      rxSync  <= rxMeta;
      rxPrev  <= rxSync;
      ackMeta <= trecieve;
      ackSync <= ackMeta;
    end
  end

  assign rxFall = rxPrev & ~rxSync;

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rxState_t          rxState, rxNext;
  logic [BAUD_W-1:0] rxCnt;
  logic [2:0]        rxBitIdx;
  logic [7:0]        rxShiftReg;
  logic [7:0]        rxByte;
  logic              rxPush;
  logic              rxCntClr, rxBitClr, rxShiftEn, rxAccept, rxReject;
  logic              rxTick, rxHalf;
`ifdef UART_PARITY_EN
  logic              parErr;
  logic              rxParSample;
`endif

  assign rxTick = (rxCnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign rxHalf = (rxCnt == BAUD_W'(HALF_BIT - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rxState <= RX_IDLE;
    else        rxState <= rxNext;
  end

  // Next state and datapath strobes
  always_comb begin
    rxNext    = rxState;
    rxCntClr  = 1'b0;
    rxBitClr  = 1'b0;
    rxShiftEn = 1'b0;
    rxAccept  = 1'b0;
    rxReject  = 1'b0;
`ifdef UART_PARITY_EN
    rxParSample = 1'b0;
`endif
    case (rxState)
      RX_IDLE: begin
        rxCntClr = 1'b1;
        if (rxFall) rxNext = RX_START;
      end
      RX_START: begin
        // Mid-bit recheck: a line already high again was a glitch
        if (rxHalf) begin
          rxCntClr = 1'b1;
          rxBitClr = 1'b1;
          rxNext   = rxSync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rxTick) begin
          rxCntClr  = 1'b1;
          rxShiftEn = 1'b1;
`ifdef UART_PARITY_EN
          if (rxBitIdx == 3'd7) rxNext = RX_PARITY;
`else
          if (rxBitIdx == 3'd7) rxNext = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rxTick) begin
          rxCntClr    = 1'b1;
          rxParSample = 1'b1;
          rxNext      = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rxTick) begin
          rxCntClr = 1'b1;
          rxNext   = RX_IDLE;
`ifdef UART_PARITY_EN
          rxAccept = rxSync & ~parErr;
`else
          rxAccept = rxSync;
`endif
          rxReject = ~rxAccept;
        end
      end
      default: rxNext = RX_IDLE;
    endcase
  end

  // RX datapath: baud counter, shifter, accept pulse, error counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxCnt      <= '0;
      rxBitIdx   <= '0;
      rxShiftReg <= '0;
      rxByte     <= '0;
      rxPush     <= 1'b0;
      err_count  <= '0;
`ifdef UART_PARITY_EN
      parErr     <= 1'b0;
`endif
    end else begin
      rxCnt <= rxCntClr ? '0 : rxCnt + BAUD_W'(1);
      if (rxBitClr) begin
        rxBitIdx <= '0;
      end else if (rxShiftEn) begin
        rxBitIdx <= rxBitIdx + 3'd1;
      end
      if (rxShiftEn) rxShiftReg <= {rxSync, rxShiftReg[7:1]};
      rxPush <= rxAccept;
      if (rxAccept) rxByte <= rxShiftReg;
      if (rxReject && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
`ifdef UART_PARITY_EN
      // Even parity: the parity bit must equal the XOR of the data bits
      if (rxParSample) parErr <= rxSync ^ (^rxShiftReg);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO and CRC
  // ---------------------------------------------------------------------------
  logic [7:0]            fifoMem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic                  fifoFull, fifoPush, fifoPop;
  logic [7:0]            popByte;
  logic                  txPop;

  assign fifoFull = (fifo_count == CNT_W'(DEPTH));
  assign fifoPush = rxPush & ~fifoFull;
  assign fifoPop  = txPop;
  assign popByte  = fifoMem[rdPtr];

  // Storage array carries no reset; validity is tracked by fifo_count
  always_ff @(posedge clk) begin
    if (fifoPush) fifoMem[wrPtr] <= rxByte;
  end

  // Pointers, occupancy, overflow flag and CRC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      crc        <= '0;
    end else begin
      if (fifoPush) wrPtr <= wrPtr + DEPTH_LOG2'(1);
      if (fifoPop)  rdPtr <= rdPtr + DEPTH_LOG2'(1);
      case ({fifoPush, fifoPop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (rxPush && fifoFull) overflow <= 1'b1;
      // Dropped bytes still count towards the CRC
      if (crc_clear)   crc <= rxPush ? crc8Byte(8'h00, rxByte) : 8'h00;
      else if (rxPush) crc <= crc8Byte(crc, rxByte);
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  txState_t           txState, txNext;
  logic               flushPend;
  logic [CNT_W-1:0]   popsLeft, loadCount;
  logic [LANE_W-1:0]  laneIdx;
  logic [DATA_W-1:0]  dataNext;
  logic               startOk, txStart, tsentSet, tsentClr;

  assign startOk   = (fifo_count >= CNT_W'(LANES)) ||
                     ((flushPend || flush) && (fifo_count != '0));
  assign loadCount = (fifo_count >= CNT_W'(LANES)) ? CNT_W'(LANES) : fifo_count;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) txState <= TX_IDLE;
    else        txState <= txNext;
  end

  // Next state and handshake strobes
  always_comb begin
    txNext   = txState;
    txStart  = 1'b0;
    txPop    = 1'b0;
    tsentSet = 1'b0;
    tsentClr = 1'b0;
    case (txState)
      TX_IDLE: begin
        if (startOk) begin
          txNext  = TX_LOAD;
          txStart = 1'b1;
        end
      end
      TX_LOAD: begin
        txPop = 1'b1;
        if (popsLeft == CNT_W'(1)) begin
          txNext   = TX_SEND;
          tsentSet = 1'b1;
        end
      end
      TX_SEND: txNext = TX_WAIT_ACK;
      TX_WAIT_ACK: begin
        if (ackSync) begin
          txNext   = TX_WAIT_REL;
          tsentClr = 1'b1;
        end
      end
      TX_WAIT_REL: begin
        // Pass through IDLE's decision in the same cycle to keep the
        // release-to-next-load latency at the synchroniser depth plus one
        if (!ackSync) begin
          if (startOk) begin
            txNext  = TX_LOAD;
            txStart = 1'b1;
          end else begin
            txNext = TX_IDLE;
          end
        end
      end
      default: txNext = TX_IDLE;
    endcase
  end

  // Word assembly: first popped byte lands in the top lane, rest stay zero
  always_comb begin
    dataNext = data;
    if (txStart) begin
      dataNext = '0;
    end else if (txPop) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (laneIdx == LANE_W'(i)) dataNext[8*(int'(LANES)-1-i) +: 8] = popByte;
      end
    end
  end

  // TX datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data      <= '0;
      tsent     <= 1'b0;
      laneIdx   <= '0;
      popsLeft  <= '0;
      flushPend <= 1'b0;
    end else begin
      data <= dataNext;
      if (txStart) begin
        laneIdx  <= '0;
        popsLeft <= loadCount;
      end else if (txPop) begin
        laneIdx  <= laneIdx + LANE_W'(1);
        popsLeft <= popsLeft - CNT_W'(1);
      end
      if (tsentSet)      tsent <= 1'b1;
      else if (tsentClr) tsent <= 1'b0;
      // A flush with nothing buffered is simply dropped
      if (txStart)                          flushPend <= 1'b0;
      else if (flush && fifo_count != '0)   flushPend <= 1'b1;
    end
  end

endmodule
